// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU over WIDTH/BPC cycles and asks CTRL to hold the
// pipeline while it works. MTHI/MTLO are written in a single cycle.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, op        EX presents an MDU op (0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                    4 MTHI, 5 MTLO, 6-7 no-op)
//   src_a, src_b     rs / rt operand values
//   cancel           pipeline flush, aborts any op in flight
//   stallreq         combinational hold request for IF..EX
//   busy             unit is not idle
//   done             one-cycle pulse when a MULT/DIV result lands in HI/LO
//   hi_o, lo_o       architectural HI and LO
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             stallreq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = WIDTH + BPC;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_lo;     // negate product / quotient at commit
  logic               neg_hi;     // negate remainder at commit
  logic [2*WIDTH-1:0] acc;        // mult: {partial sum, multiplier}; div: dividend/quotient in low half
  logic [WIDTH-1:0]   rem;        // running remainder
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude

  // Operand magnitudes for the accept cycle
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    is_signed = (op == 3'd0) || (op == 3'd2);
    a_neg     = is_signed & src_a[WIDTH-1];
    b_neg     = is_signed & src_b[WIDTH-1];
    a_abs     = a_neg ? -src_a : src_a;
    b_abs     = b_neg ? -src_b : src_b;
  end

  // One iteration of both datapaths plus the sign-corrected final result
  logic [PW-1:0]      partial;
  logic [PW-1:0]      upper;
  logic [2*WIDTH-1:0] acc_mul;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   q_nx;
  logic [WIDTH-1:0]   r_nx;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   hi_fin;
  logic [WIDTH-1:0]   lo_fin;

  always_comb begin
    partial = PW'(opnd) * PW'(acc[BPC-1:0]);
    upper   = PW'(acc[2*WIDTH-1:WIDTH]) + partial;
    acc_mul = (2*WIDTH)'({upper, acc[WIDTH-1:0]} >> BPC);

    q_nx  = acc[WIDTH-1:0];
    r_nx  = rem;
    trial = '0;
    for (int i = 0; i < int'(BPC); i++) begin
      trial = {r_nx, q_nx[WIDTH-1]};
      q_nx  = q_nx << 1;
      if (trial >= {1'b0, opnd}) begin
        trial   = trial - {1'b0, opnd};
        q_nx[0] = 1'b1;
      end
      r_nx = trial[WIDTH-1:0];
    end

    prod_fin = neg_lo ? -acc_mul : acc_mul;
    if (is_div) begin
      lo_fin = neg_lo ? -q_nx : q_nx;
      hi_fin = neg_hi ? -r_nx : r_nx;
    end else begin
      hi_fin = prod_fin[2*WIDTH-1:WIDTH];
      lo_fin = prod_fin[WIDTH-1:0];
    end
  end

  // Control FSM, operand latch, iteration and HI/LO commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      opnd   <= '0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else if (cancel) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              state  <= CALC;
              cnt    <= CW'(N);
              is_div <= op[1];
              rem    <= '0;
              if (op[1]) begin
                opnd <= b_abs;
                // Zero divisor: raw dividend passes through as the remainder
                if (src_b == '0) begin
                  acc    <= {{WIDTH{1'b0}}, src_a};
                  neg_lo <= 1'b0;
                  neg_hi <= 1'b0;
                end else begin
                  acc    <= {{WIDTH{1'b0}}, a_abs};
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= a_neg;
                end
              end else begin
                opnd   <= a_abs;
                acc    <= {{WIDTH{1'b0}}, b_abs};
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= 1'b0;
              end
            end else if (op == 3'd4) begin
              hi_o <= src_a;
            end else if (op == 3'd5) begin
              lo_o <= src_a;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            acc <= {{WIDTH{1'b0}}, q_nx};
            rem <= r_nx;
          end else begin
            acc <= acc_mul;
          end
          if (cnt == CW'(1)) begin
            hi_o  <= hi_fin;
            lo_o  <= lo_fin;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign stallreq = !cancel && (((state == IDLE) && start && !op[2]) || (state == CALC));

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start    [2];
  logic [2:0]  op       [2];
  logic [31:0] a        [2];
  logic [31:0] b        [2];
  logic        cancel   [2];
  logic        stallreq [2];
  logic        busy     [2];
  logic        done     [2];
  logic [31:0] hi       [2];
  logic [31:0] lo       [2];

  mdu_iter #(.WIDTH(32), .BPC(1)) u_bpc1 (
    .clk(clk), .rst(rst), .start(start[0]), .op(op[0]), .src_a(a[0]), .src_b(b[0]),
    .cancel(cancel[0]), .stallreq(stallreq[0]), .busy(busy[0]), .done(done[0]),
    .hi_o(hi[0]), .lo_o(lo[0])
  );

  mdu_iter #(.WIDTH(32), .BPC(4)) u_bpc4 (
    .clk(clk), .rst(rst), .start(start[1]), .op(op[1]), .src_a(a[1]), .src_b(b[1]),
    .cancel(cancel[1]), .stallreq(stallreq[1]), .busy(busy[1]), .done(done[1]),
    .hi_o(hi[1]), .lo_o(lo[1])
  );

  int passed = 0;
  int total  = 0;
  int dcount [2];

  always @(posedge clk) begin
    if (done[0] === 1'b1) dcount[0]++;
    if (done[1] === 1'b1) dcount[1]++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: plain arithmetic on the architectural definition of each op
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] h, output logic [31:0] l);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'(int'(x));
    sy = longint'(int'(y));
    h = '0;
    l = '0;
    case (o)
      3'd0: begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = 64'(x) * 64'(y); h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (y == 32'd0) begin l = 32'hFFFF_FFFF; h = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = 32'd0; end
        else begin l = 32'(int'(x) / int'(y)); h = 32'(int'(x) % int'(y)); end
      end
      3'd3: begin
        if (y == 32'd0) begin l = 32'hFFFF_FFFF; h = x; end
        else begin l = x / y; h = x % y; end
      end
      default: ;
    endcase
  endfunction

  // Issue one MULT/DIV on unit u and check stall length, DONE cycle, and result
  task automatic run(input int u, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input bit hold, input string tag);
    logic [31:0] eh, el;
    int stalls, n, d0;
    n = (u == 0) ? 32 : 8;
    ref_model(o, x, y, eh, el);
    d0 = dcount[u];
    @(negedge clk);
    start[u] = 1'b1; op[u] = o; a[u] = x; b[u] = y;
    stalls = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (stallreq[u] !== 1'b1) break;
      stalls++;
      @(negedge clk);
      if (!hold) start[u] = 1'b0;
      a[u] = $urandom; b[u] = $urandom;   // operands must already be latched
    end
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(n + 1));
    chk({tag, " done"}, 64'(done[u]), 64'd1);
    chk({tag, " busy_in_done"}, 64'(busy[u]), 64'd1);
    chk({tag, " hi"}, 64'(hi[u]), 64'(eh));
    chk({tag, " lo"}, 64'(lo[u]), 64'(el));
    @(negedge clk);
    start[u] = 1'b0;
    #1;
    chk({tag, " busy_after"}, 64'(busy[u]), 64'd0);
    chk({tag, " stall_after"}, 64'(stallreq[u]), 64'd0);
    chk({tag, " done_pulses"}, 64'(dcount[u]), 64'(d0 + 1));
  endtask

  initial begin
    int d0;
    logic [2:0] ro;
    logic [31:0] rx, ry;
    int sel;
    dcount[0] = 0; dcount[1] = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; op[i] = 3'd0; a[i] = '0; b[i] = '0; cancel[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset stallreq", 64'(stallreq[i]), 64'd0);
      chk("reset busy", 64'(busy[i]), 64'd0);
      chk("reset done", 64'(done[i]), 64'd0);
      chk("reset hi", 64'(hi[i]), 64'd0);
      chk("reset lo", 64'(lo[i]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run(0, 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "mult_neg1x2");
    chk("mult_neg1x2 hi_const", 64'(hi[0]), 64'h0000_0000_FFFF_FFFF);
    run(0, 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "multu_ffx2");
    chk("multu_ffx2 hi_const", 64'(hi[0]), 64'd1);
    run(0, 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_m7_2");
    chk("div_m7_2 lo_const", 64'(lo[0]), 64'h0000_0000_FFFF_FFFD);
    run(0, 3'd3, 32'd7, 32'd2, 1'b0, "divu_7_2");
    chk("divu_7_2 lo_const", 64'(lo[0]), 64'd3);
    run(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    chk("div_ovf lo_const", 64'(lo[0]), 64'h0000_0000_8000_0000);
    run(0, 3'd3, 32'h0000_1234, 32'd0, 1'b0, "divu_by0");
    chk("divu_by0 hi_const", 64'(hi[0]), 64'h1234);
    run(0, 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0, "div_neg_by0");

    // MTHI / MTLO on consecutive cycles, then a reserved op
    @(negedge clk);
    start[0] = 1'b1; op[0] = 3'd4; a[0] = 32'hA5A5_A5A5;
    #1 chk("mthi stallreq", 64'(stallreq[0]), 64'd0);
    @(negedge clk);
    op[0] = 3'd5; a[0] = 32'h5A5A_5A5A;
    #1 chk("mthi visible", 64'(hi[0]), 64'hA5A5_A5A5);
    chk("mtlo stallreq", 64'(stallreq[0]), 64'd0);
    @(negedge clk);
    op[0] = 3'd6; a[0] = 32'h1111_1111;
    #1 chk("mtlo visible", 64'(lo[0]), 64'h5A5A_5A5A);
    chk("reserved stallreq", 64'(stallreq[0]), 64'd0);
    @(negedge clk);
    start[0] = 1'b0;
    #1 chk("reserved busy", 64'(busy[0]), 64'd0);
    chk("reserved hi", 64'(hi[0]), 64'hA5A5_A5A5);
    chk("reserved lo", 64'(lo[0]), 64'h5A5A_5A5A);

    // MULT cancelled in CALC cycle 10
    d0 = dcount[0];
    @(negedge clk);
    start[0] = 1'b1; op[0] = 3'd0; a[0] = 32'hFFFF_FFFF; b[0] = 32'd2;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    #1 chk("calc10 stallreq", 64'(stallreq[0]), 64'd1);
    cancel[0] = 1'b1;
    #1 chk("cancel stallreq", 64'(stallreq[0]), 64'd0);
    @(negedge clk);
    cancel[0] = 1'b0;
    #1 chk("cancel busy", 64'(busy[0]), 64'd0);
    chk("cancel hi", 64'(hi[0]), 64'hA5A5_A5A5);
    chk("cancel lo", 64'(lo[0]), 64'h5A5A_5A5A);
    repeat (40) @(negedge clk);
    chk("cancel no_done", 64'(dcount[0]), 64'(d0));

    // Start held high through DONE must not launch a second op
    run(0, 3'd1, 32'h0000_1000, 32'h0000_0300, 1'b1, "hold_start");
    repeat (3) @(negedge clk);
    #1 chk("hold_start stays_idle", 64'(busy[0]), 64'd0);

    // Reset during CALC
    @(negedge clk);
    start[0] = 1'b1; op[0] = 3'd1; a[0] = 32'h1234_5678; b[0] = 32'h9ABC_DEF0;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid hi", 64'(hi[0]), 64'd0);
    chk("rst_mid lo", 64'(lo[0]), 64'd0);
    chk("rst_mid busy", 64'(busy[0]), 64'd0);

    // BPC=4 directed case
    run(1, 3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, "bpc4_multu");
    chk("bpc4_multu hi_const", 64'(hi[1]), 64'd1);
    run(1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "bpc4_div");

    // Randomized ops on both units
    for (int k = 0; k < 45; k++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = 32'd0;
      else if (sel == 1) ry = 32'($urandom_range(1, 15));
      else if (sel == 2) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (sel == 3) ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      run((k < 30) ? 0 : 1, ro, rx, ry, 1'b0, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
